// File: rtl/snn_param_core.sv
// Two-image SNN feature datapath: 3x3 conv -> quantize -> 2x2 max-pool -> per-row FC -> quantize,
// then a thresholded L1/Chebyshev distance between the A and B feature vectors.
module snn_param_core #(
  parameter int IMG_W  = 6,
  parameter int THRESH = 16,
  parameter int OUT_W  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       img,
  input  logic [7:0]       ker,
  input  logic [7:0]       weight,
  input  logic             dist_mode,
  output logic             busy,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data
);
  localparam int C     = IMG_W - 2;
  localparam int P     = C / 2;
  localparam int N     = P * P;
  localparam int NPIX  = IMG_W * IMG_W;
  localparam int FRAME = 2 * NPIX;
  localparam int SR    = 2 * IMG_W + 2;
  localparam int PIX_W = $clog2(FRAME);
  localparam int RC_W  = $clog2(IMG_W);
  localparam int PW    = (P > 1) ? $clog2(P) : 1;
  localparam int FW    = $clog2(P * 65025 + 1);
  localparam int DW    = $clog2(N * 255 + 1) + 1;
  localparam logic [31:0] SAT_MAX = 32'((64'd1 << OUT_W) - 64'd1);

  logic [PIX_W-1:0] pix_q, pix_d;
  logic [RC_W-1:0]  row_q, row_d, col_q, col_d;
  logic             done_q, done_d, busy_q, busy_d, mode_q, mode_d;
  logic [7:0]       ker_q [9], ker_d [9];
  logic [7:0]       w_q [N], w_d [N];
  logic [7:0]       sr_q [SR], sr_d [SR];
  logic             s1_v_q, s1_v_d, s1_last_q, s1_last_d, s1_b_q, s1_b_d;
  logic [7:0]       s1_q_q, s1_q_d;
  logic [RC_W-1:0]  s1_cr_q, s1_cr_d, s1_cc_q, s1_cc_d;
  logic [7:0]       pm_q [P], pm_d [P];
  logic [FW-1:0]    fc_q [P], fc_d [P];
  logic [7:0]       da_q [N], da_d [N];
  logic [DW-1:0]    acc_q, acc_d;
  logic             s2_last_q, s2_last_d, out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;

  logic             accept, last_pix;
  logic [7:0]       win [9];
  logic [19:0]      conv_sum;
  logic [7:0]       conv_q;
  logic [PW-1:0]    pj;
  logic [7:0]       m_val, wsel, fval, dval, da_sel;
  logic [FW-1:0]    fsum;
  logic [DW-1:0]    fold;
  logic [31:0]      acc_ext;

  // Window tap gi sits (2-row)*IMG_W + (2-col) pixels behind the incoming one.
  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_win
      localparam int OFF = (2 - gi / 3) * IMG_W + (2 - gi % 3);
      if (OFF == 0) begin : g_cur
        assign win[gi] = img;
      end else begin : g_buf
        assign win[gi] = sr_q[OFF-1];
      end
    end
  endgenerate

  always_comb begin
    conv_sum = '0;
    for (int i = 0; i < 9; i++) conv_sum = conv_sum + 20'(win[i]) * 20'(ker_q[i]);
    conv_q = 8'(conv_sum / 20'd2295);
  end

  always_comb begin
    accept    = in_valid && !done_q;
    last_pix  = (pix_q == PIX_W'(FRAME - 1));
    pix_d     = pix_q;
    row_d     = row_q;
    col_d     = col_q;
    done_d    = done_q;
    busy_d    = busy_q;
    mode_d    = mode_q;
    ker_d     = ker_q;
    w_d       = w_q;
    sr_d      = sr_q;
    s1_v_d    = accept && (row_q >= RC_W'(2)) && (col_q >= RC_W'(2));
    s1_last_d = accept && last_pix;
    s1_b_d    = (pix_q >= PIX_W'(NPIX));
    s1_q_d    = conv_q;
    s1_cr_d   = row_q - RC_W'(2);
    s1_cc_d   = col_q - RC_W'(2);
    if (accept) begin
      pix_d = last_pix ? '0 : pix_q + PIX_W'(1);
      if (col_q == RC_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RC_W'(IMG_W - 1)) ? '0 : row_q + RC_W'(1);
      end else begin
        col_d = col_q + RC_W'(1);
      end
      sr_d[0] = img;
      for (int i = 1; i < SR; i++) sr_d[i] = sr_q[i-1];
      for (int i = 0; i < 9; i++) if (pix_q == PIX_W'(i)) ker_d[i] = ker;
      for (int i = 0; i < N; i++) if (pix_q == PIX_W'(i)) w_d[i] = weight;
      if (pix_q == '0) begin
        mode_d = dist_mode;
        busy_d = 1'b1;
      end
      if (last_pix) done_d = 1'b1;
    end
    // The result cycle closes the frame; input is accepted again from the next cycle.
    if (out_valid_q) begin
      busy_d = 1'b0;
      done_d = 1'b0;
    end
  end

  always_comb begin
    pm_d      = pm_q;
    fc_d      = fc_q;
    da_d      = da_q;
    acc_d     = acc_q;
    pj        = PW'(s1_cc_q >> 1);
    m_val     = '0;
    wsel      = '0;
    fsum      = '0;
    fval      = '0;
    dval      = '0;
    da_sel    = '0;
    fold      = acc_q;
    s2_last_d = s1_v_q && s1_last_q;
    if (s1_v_q) begin
      for (int jj = 0; jj < P; jj++) begin
        if (PW'(jj) == pj) begin
          m_val    = (pm_q[jj] > s1_q_q) ? pm_q[jj] : s1_q_q;
          pm_d[jj] = (!s1_cr_q[0] && !s1_cc_q[0]) ? s1_q_q : m_val;
        end
      end
      // Odd row, odd column completes pooled m[i][pj]; fold it into every FC column.
      if (s1_cr_q[0] && s1_cc_q[0]) begin
        for (int jj = 0; jj < P; jj++) begin
          wsel = '0;
          for (int kk = 0; kk < P; kk++) if (PW'(kk) == pj) wsel = w_q[kk*P+jj];
          fsum     = ((pj == '0) ? '0 : fc_q[jj]) + FW'(m_val) * FW'(wsel);
          fc_d[jj] = fsum;
          fval     = 8'(fsum / FW'(P * 255));
          if (pj == PW'(P - 1)) begin
            for (int ii = 0; ii < P; ii++) begin
              if (PW'(ii) == PW'(s1_cr_q >> 1)) begin
                if (!s1_b_q) begin
                  da_d[ii*P+jj] = fval;
                end else begin
                  da_sel = da_q[ii*P+jj];
                  dval   = (da_sel >= fval) ? da_sel - fval : fval - da_sel;
                  if (mode_q) fold = (DW'(dval) > fold) ? DW'(dval) : fold;
                  else        fold = fold + DW'(dval);
                end
              end
            end
          end
        end
        acc_d = fold;
      end
    end
    if (accept && pix_q == '0) acc_d = '0;

    acc_ext     = 32'(acc_q);
    out_valid_d = s2_last_q;
    out_data_d  = '0;
    if (s2_last_q) begin
      if (acc_ext < 32'(THRESH))   out_data_d = '0;
      else if (acc_ext > SAT_MAX)  out_data_d = OUT_W'(SAT_MAX);
      else                         out_data_d = OUT_W'(acc_ext);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      mode_q      <= 1'b0;
      for (int i = 0; i < 9; i++)  ker_q[i] <= '0;
      for (int i = 0; i < N; i++)  w_q[i]   <= '0;
      for (int i = 0; i < SR; i++) sr_q[i]  <= '0;
      for (int i = 0; i < P; i++)  pm_q[i]  <= '0;
      for (int i = 0; i < P; i++)  fc_q[i]  <= '0;
      for (int i = 0; i < N; i++)  da_q[i]  <= '0;
      s1_v_q      <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_b_q      <= 1'b0;
      s1_q_q      <= '0;
      s1_cr_q     <= '0;
      s1_cc_q     <= '0;
      acc_q       <= '0;
      s2_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      pix_q       <= pix_d;
      row_q       <= row_d;
      col_q       <= col_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      mode_q      <= mode_d;
      ker_q       <= ker_d;
      w_q         <= w_d;
      sr_q        <= sr_d;
      pm_q        <= pm_d;
      fc_q        <= fc_d;
      da_q        <= da_d;
      s1_v_q      <= s1_v_d;
      s1_last_q   <= s1_last_d;
      s1_b_q      <= s1_b_d;
      s1_q_q      <= s1_q_d;
      s1_cr_q     <= s1_cr_d;
      s1_cc_q     <= s1_cc_d;
      acc_q       <= acc_d;
      s2_last_q   <= s2_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule
